// File: rtl/pke_arb.sv
// pke_arb: two-port packet arbiter feeding the pke pipeline.
// Each grant covers one packet. The packet ends on a descriptor strobe
// (valid_wr) or when the watchdog expires. Frames are re-registered with
// one cycle of latency. Protocol violations and timeouts are counted.
module pke_arb #(
  parameter logic [9:0] TMO_CYC = 10'd1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_prio_en,
  input  logic         in_arb0_req,
  input  logic [133:0] in_arb0_data,
  input  logic         in_arb0_data_wr,
  input  logic         in_arb0_valid,
  input  logic         in_arb0_valid_wr,
  input  logic         in_arb1_req,
  input  logic [133:0] in_arb1_data,
  input  logic         in_arb1_data_wr,
  input  logic         in_arb1_valid,
  input  logic         in_arb1_valid_wr,
  output logic         out_arb0_gnt,
  output logic         out_arb1_gnt,
  output logic [133:0] out_arb_data,
  output logic         out_arb_data_wr,
  output logic         out_arb_valid,
  output logic         out_arb_valid_wr,
  output logic [31:0]  arb_pkt0_cnt,
  output logic [31:0]  arb_pkt1_cnt,
  output logic [15:0]  arb_err_cnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [1:0] FRM_FIRST  = 2'b01;
  localparam logic [1:0] FRM_MIDDLE = 2'b11;
  localparam logic [1:0] FRM_LAST   = 2'b10;

  // Per-port inputs packed so the granted port can be selected by index
  logic [1:0]   req;
  logic [1:0]   dwr;
  logic [1:0]   vwr;
  logic [1:0]   vld;
  logic [133:0] dat [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req[gi] = (gi == 0) ? in_arb0_req      : in_arb1_req;
    assign dwr[gi] = (gi == 0) ? in_arb0_data_wr  : in_arb1_data_wr;
    assign vwr[gi] = (gi == 0) ? in_arb0_valid_wr : in_arb1_valid_wr;
    assign vld[gi] = (gi == 0) ? in_arb0_valid    : in_arb1_valid;
    assign dat[gi] = (gi == 0) ? in_arb0_data     : in_arb1_data;
  end

  state_t       state_q, state_d;
  logic         last_srv_q, last_srv_d;
  logic         pkt_open_q, pkt_open_d;
  logic [9:0]   wdog_q, wdog_d;
  logic [133:0] data_q, data_d;
  logic         data_wr_q, data_wr_d;
  logic         valid_q, valid_d;
  logic         valid_wr_q, valid_wr_d;
  logic [31:0]  pkt0_cnt_q, pkt0_cnt_d;
  logic [31:0]  pkt1_cnt_q, pkt1_cnt_d;
  logic [15:0]  err_cnt_q, err_cnt_d;

  logic         err_evt;
  logic [1:0]   pkt_done;
  logic         sel_vld;
  logic         sel_port;
  logic         gnt_idx;
  logic         oth_idx;
  logic [1:0]   frame_typ;

  // Arbitration, frame checking, forwarding and watchdog
  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    pkt_open_d = pkt_open_q;
    wdog_d     = '0;
    data_d     = '0;
    data_wr_d  = 1'b0;
    valid_d    = 1'b0;
    valid_wr_d = 1'b0;
    err_evt    = 1'b0;
    pkt_done   = 2'b00;
    gnt_idx    = (state_q == GNT1);
    oth_idx    = ~gnt_idx;
    frame_typ  = dat[gnt_idx][133:132];

    // A tie goes to port 1 under strict priority, else to the port not served last
    sel_vld  = 1'b0;
    sel_port = 1'b0;
    if (req[0] && req[1]) begin
      sel_vld  = 1'b1;
      sel_port = cfg_prio_en ? 1'b1 : ~last_srv_q;
    end else if (req[0]) begin
      sel_vld  = 1'b1;
      sel_port = 1'b0;
    end else if (req[1]) begin
      sel_vld  = 1'b1;
      sel_port = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Nobody holds a grant, so any strobe is a violation
        err_evt    = (|dwr) | (|vwr);
        pkt_open_d = 1'b0;
        if (sel_vld) begin
          state_d    = sel_port ? GNT1 : GNT0;
          last_srv_d = sel_port;
        end
      end
      GNT0, GNT1: begin
        if (valid_wr_q) begin
          // Descriptor went out last cycle: grant is finished, nothing is accepted
          err_evt           = (|dwr) | (|vwr);
          state_d           = IDLE;
          pkt_open_d        = 1'b0;
          pkt_done[gnt_idx] = 1'b1;
        end else begin
          err_evt = dwr[oth_idx] | vwr[oth_idx];
          if (dwr[gnt_idx]) begin
            if (frame_typ == FRM_FIRST) begin
              // A restart inside an open packet is passed on but flagged
              if (pkt_open_q) err_evt = 1'b1;
              data_wr_d  = 1'b1;
              data_d     = dat[gnt_idx];
              pkt_open_d = 1'b1;
            end else if (pkt_open_q && (frame_typ == FRM_MIDDLE || frame_typ == FRM_LAST)) begin
              data_wr_d = 1'b1;
              data_d    = dat[gnt_idx];
              if (frame_typ == FRM_LAST) pkt_open_d = 1'b0;
            end else begin
              err_evt = 1'b1;
            end
          end
          if (vwr[gnt_idx]) begin
            valid_wr_d = 1'b1;
            valid_d    = vld[gnt_idx];
          end
          if (!(dwr[gnt_idx] || vwr[gnt_idx])) begin
            if ((wdog_q + 10'd1) == TMO_CYC) begin
              // Stalled source: abandon the packet without a descriptor
              err_evt    = 1'b1;
              state_d    = IDLE;
              pkt_open_d = 1'b0;
            end else begin
              wdog_d = wdog_q + 10'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pkt0_cnt_d = pkt0_cnt_q + {31'd0, pkt_done[0]};
    pkt1_cnt_d = pkt1_cnt_q + {31'd0, pkt_done[1]};
    err_cnt_d  = err_cnt_q + {15'd0, err_evt};
  end

  // State, output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_srv_q <= 1'b1;
      pkt_open_q <= 1'b0;
      wdog_q     <= '0;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
      pkt0_cnt_q <= '0;
      pkt1_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
      pkt_open_q <= pkt_open_d;
      wdog_q     <= wdog_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      pkt0_cnt_q <= pkt0_cnt_d;
      pkt1_cnt_q <= pkt1_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_arb0_gnt     = (state_q == GNT0);
  assign out_arb1_gnt     = (state_q == GNT1);
  assign out_arb_data     = data_q;
  assign out_arb_data_wr  = data_wr_q;
  assign out_arb_valid    = valid_q;
  assign out_arb_valid_wr = valid_wr_q;
  assign arb_pkt0_cnt     = pkt0_cnt_q;
  assign arb_pkt1_cnt     = pkt1_cnt_q;
  assign arb_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pke_arb.sv
// tb_pke_arb: directed vector table, hand-written arbitration/timeout
// sequences, then random traffic checked against a packet-level model.
module tb_pke_arb;

  localparam logic [9:0] TMO = 10'd16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_prio_en = 1'b0;
  logic         in_arb0_req = 1'b0, in_arb1_req = 1'b0;
  logic [133:0] in_arb0_data = '0, in_arb1_data = '0;
  logic         in_arb0_data_wr = 1'b0, in_arb1_data_wr = 1'b0;
  logic         in_arb0_valid = 1'b0, in_arb1_valid = 1'b0;
  logic         in_arb0_valid_wr = 1'b0, in_arb1_valid_wr = 1'b0;
  logic         out_arb0_gnt, out_arb1_gnt;
  logic [133:0] out_arb_data;
  logic         out_arb_data_wr, out_arb_valid, out_arb_valid_wr;
  logic [31:0]  arb_pkt0_cnt, arb_pkt1_cnt;
  logic [15:0]  arb_err_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pke_arb #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_prio_en(cfg_prio_en),
    .in_arb0_req(in_arb0_req), .in_arb0_data(in_arb0_data),
    .in_arb0_data_wr(in_arb0_data_wr), .in_arb0_valid(in_arb0_valid),
    .in_arb0_valid_wr(in_arb0_valid_wr),
    .in_arb1_req(in_arb1_req), .in_arb1_data(in_arb1_data),
    .in_arb1_data_wr(in_arb1_data_wr), .in_arb1_valid(in_arb1_valid),
    .in_arb1_valid_wr(in_arb1_valid_wr),
    .out_arb0_gnt(out_arb0_gnt), .out_arb1_gnt(out_arb1_gnt),
    .out_arb_data(out_arb_data), .out_arb_data_wr(out_arb_data_wr),
    .out_arb_valid(out_arb_valid), .out_arb_valid_wr(out_arb_valid_wr),
    .arb_pkt0_cnt(arb_pkt0_cnt), .arb_pkt1_cnt(arb_pkt1_cnt),
    .arb_err_cnt(arb_err_cnt)
  );

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ports();
    in_arb0_data_wr = 1'b0; in_arb0_valid_wr = 1'b0; in_arb0_valid = 1'b0;
    in_arb1_data_wr = 1'b0; in_arb1_valid_wr = 1'b0; in_arb1_valid = 1'b0;
    in_arb0_data = '0; in_arb1_data = '0;
  endtask

  task automatic do_reset();
    clear_ports();
    in_arb0_req = 1'b0; in_arb1_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [133:0] rnd_data(input logic [1:0] t);
    logic [3:0] lo;
    lo = 4'($urandom());
    return {t, $urandom(), $urandom(), $urandom(), $urandom(), lo};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst, req0, dwr0, vwr0, dwr1;
    logic [1:0] typ;
    bit         e_gnt0, e_dwr, e_vwr;
    int         e_pkt0, e_err;
  } vec_t;

  vec_t tbl[18];

  // ---------------- waits for a grant, sends a 3-frame packet ----------------
  task automatic run_pkt(output int port);
    int n;
    logic [133:0] d;
    logic [1:0] t;
    n = 0;
    port = -1;
    while (!(out_arb0_gnt || out_arb1_gnt) && n < 20) begin
      n++;
      tick();
    end
    if (!(out_arb0_gnt || out_arb1_gnt)) begin
      total++; bad++;
      $display("FAIL pkt_grant_wait act=no_grant exp=grant");
      return;
    end
    port = out_arb1_gnt ? 1 : 0;
    for (int f = 0; f < 3; f++) begin
      t = (f == 0) ? 2'b01 : ((f == 1) ? 2'b11 : 2'b10);
      d = rnd_data(t);
      if (port == 0) begin
        in_arb0_data = d; in_arb0_data_wr = 1'b1;
        in_arb0_valid_wr = (f == 2); in_arb0_valid = (f == 2);
      end else begin
        in_arb1_data = d; in_arb1_data_wr = 1'b1;
        in_arb1_valid_wr = (f == 2); in_arb1_valid = (f == 2);
      end
      tick();
      chk("pkt_frame", out_arb_data, d);
    end
    clear_ports();
    chk("pkt_vwr", 134'(out_arb_valid_wr), 134'(1));
    tick();
    chk("pkt_gnt_drop", 134'(out_arb0_gnt | out_arb1_gnt), 134'(0));
  endtask

  // ---------------- reference model (packet-level) ----------------
  bit           s_rst, s_prio;
  bit           s_rq[2], s_dw[2], s_vw[2], s_vl[2];
  logic [133:0] s_dt[2];

  int           m_port, m_last, m_wd;
  bit           m_open, m_vpend;
  logic [31:0]  m_cnt[2];
  logic [15:0]  m_err;
  logic [133:0] e_data;
  bit           e_dwr, e_vld, e_vwr;

  task automatic model_step();
    bit err, fwd;
    int g;
    e_data = '0; e_dwr = 0; e_vld = 0; e_vwr = 0;
    err = 0; fwd = 0;
    if (s_rst) begin
      m_port = -1; m_last = 1; m_open = 0; m_wd = 0; m_vpend = 0;
      m_cnt[0] = '0; m_cnt[1] = '0; m_err = '0;
      return;
    end
    if (m_port < 0) begin
      if (s_dw[0] || s_dw[1] || s_vw[0] || s_vw[1]) err = 1;
      if (s_rq[0] && s_rq[1]) g = s_prio ? 1 : 1 - m_last;
      else if (s_rq[0]) g = 0;
      else if (s_rq[1]) g = 1;
      else g = -1;
      if (g >= 0) begin
        m_port = g; m_last = g; m_open = 0; m_wd = 0; m_vpend = 0;
      end
    end else if (m_vpend) begin
      if (s_dw[0] || s_dw[1] || s_vw[0] || s_vw[1]) err = 1;
      m_cnt[m_port] = m_cnt[m_port] + 32'd1;
      m_port = -1; m_vpend = 0; m_open = 0;
    end else begin
      g = m_port;
      if (s_dw[1-g] || s_vw[1-g]) err = 1;
      if (s_dw[g]) begin
        case (s_dt[g][133:132])
          2'b01: begin if (m_open) err = 1; fwd = 1; m_open = 1; end
          2'b11: if (m_open) fwd = 1; else err = 1;
          2'b10: if (m_open) begin fwd = 1; m_open = 0; end else err = 1;
          default: err = 1;
        endcase
        if (fwd) begin e_dwr = 1; e_data = s_dt[g]; end
      end
      if (s_vw[g]) begin e_vwr = 1; e_vld = s_vl[g]; m_vpend = 1; end
      if (s_dw[g] || s_vw[g]) m_wd = 0;
      else begin
        m_wd++;
        if (m_wd == int'(TMO)) begin err = 1; m_port = -1; m_wd = 0; m_open = 0; end
      end
    end
    if (err) m_err = m_err + 16'd1;
  endtask

  task automatic apply_s();
    rst = s_rst; cfg_prio_en = s_prio;
    in_arb0_req = s_rq[0]; in_arb1_req = s_rq[1];
    in_arb0_data = s_dt[0]; in_arb1_data = s_dt[1];
    in_arb0_data_wr = s_dw[0]; in_arb1_data_wr = s_dw[1];
    in_arb0_valid_wr = s_vw[0]; in_arb1_valid_wr = s_vw[1];
    in_arb0_valid = s_vl[0]; in_arb1_valid = s_vl[1];
  endtask

  task automatic compare_model();
    chk("r_gnt0", 134'(out_arb0_gnt), 134'(m_port == 0));
    chk("r_gnt1", 134'(out_arb1_gnt), 134'(m_port == 1));
    chk("r_data", out_arb_data, e_data);
    chk("r_data_wr", 134'(out_arb_data_wr), 134'(e_dwr));
    chk("r_valid", 134'(out_arb_valid), 134'(e_vld));
    chk("r_valid_wr", 134'(out_arb_valid_wr), 134'(e_vwr));
    chk("r_pkt0", 134'(arb_pkt0_cnt), 134'(m_cnt[0]));
    chk("r_pkt1", 134'(arb_pkt1_cnt), 134'(m_cnt[1]));
    chk("r_err", 134'(arb_err_cnt), 134'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [133:0] rd;
    int p, n, stall, k;
    logic [1:0] t;

    // rst dwr0 vwr0 dwr1 fields follow req0; expectations observed after the edge
    //            rst req0 dwr0 vwr0 dwr1 typ    gnt0 dwr vwr pkt0 err
    tbl[0]  = '{1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 2'b01, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 1, 2'b11, 1, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 1, 1, 0, 2'b10, 1, 1, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1};
    tbl[6]  = '{0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 1};
    tbl[7]  = '{0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 1, 2};
    tbl[8]  = '{0, 0, 1, 0, 0, 2'b01, 1, 1, 0, 1, 2};
    tbl[9]  = '{0, 0, 1, 1, 0, 2'b01, 1, 1, 1, 1, 3};
    tbl[10] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2, 3};
    tbl[11] = '{0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 2, 4};
    tbl[12] = '{0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 2, 4};
    tbl[13] = '{0, 1, 1, 0, 0, 2'b01, 1, 1, 0, 2, 4};
    tbl[14] = '{1, 1, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0};

    for (int i = 0; i < 18; i++) begin
      rd = {tbl[i].typ, {4{32'hA5A50000 + 32'(i)}}, 4'(i)};
      rst = tbl[i].rst;
      in_arb0_req = tbl[i].req0; in_arb1_req = 1'b0;
      in_arb0_data = rd; in_arb1_data = ~rd;
      in_arb0_data_wr = tbl[i].dwr0;
      in_arb0_valid_wr = tbl[i].vwr0; in_arb0_valid = tbl[i].vwr0;
      in_arb1_data_wr = tbl[i].dwr1;
      tick();
      chk($sformatf("v%0d_gnt0", i), 134'(out_arb0_gnt), 134'(tbl[i].e_gnt0));
      chk($sformatf("v%0d_gnt1", i), 134'(out_arb1_gnt), 134'(0));
      chk($sformatf("v%0d_dwr", i), 134'(out_arb_data_wr), 134'(tbl[i].e_dwr));
      chk($sformatf("v%0d_data", i), out_arb_data, tbl[i].e_dwr ? rd : 134'(0));
      chk($sformatf("v%0d_vwr", i), 134'(out_arb_valid_wr), 134'(tbl[i].e_vwr));
      chk($sformatf("v%0d_valid", i), 134'(out_arb_valid), 134'(tbl[i].e_vwr));
      chk($sformatf("v%0d_pkt0", i), 134'(arb_pkt0_cnt), 134'(tbl[i].e_pkt0));
      chk($sformatf("v%0d_err", i), 134'(arb_err_cnt), 134'(tbl[i].e_err));
    end
    clear_ports();

    // Round robin: both requesting, grants alternate starting with port 0
    do_reset();
    cfg_prio_en = 1'b0; in_arb0_req = 1'b1; in_arb1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_pkt(p);
      chk($sformatf("rr_order%0d", i), 134'(p), 134'(i % 2));
    end
    chk("rr_pkt0", 134'(arb_pkt0_cnt), 134'(2));
    chk("rr_pkt1", 134'(arb_pkt1_cnt), 134'(2));
    chk("rr_err", 134'(arb_err_cnt), 134'(0));

    // Strict priority: port 1 wins until it drops its request
    do_reset();
    cfg_prio_en = 1'b1; in_arb0_req = 1'b1; in_arb1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_pkt(p);
      chk($sformatf("prio_order%0d", i), 134'(p), 134'(1));
    end
    in_arb1_req = 1'b0;
    run_pkt(p);
    chk("prio_port0_after", 134'(p), 134'(0));
    chk("prio_pkt1", 134'(arb_pkt1_cnt), 134'(3));
    chk("prio_pkt0", 134'(arb_pkt0_cnt), 134'(1));

    // Watchdog: first frame then silence, grant must drop after TMO cycles
    do_reset();
    cfg_prio_en = 1'b0; in_arb0_req = 1'b1;
    tick();
    chk("tmo_gnt", 134'(out_arb0_gnt), 134'(1));
    in_arb0_data = rnd_data(2'b01); in_arb0_data_wr = 1'b1; in_arb0_req = 1'b0;
    tick();
    clear_ports();
    n = 0;
    while (out_arb0_gnt === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 134'(n), 134'(TMO));
    chk("tmo_gnt_low", 134'(out_arb0_gnt), 134'(0));
    chk("tmo_err", 134'(arb_err_cnt), 134'(1));
    chk("tmo_pkt0", 134'(arb_pkt0_cnt), 134'(0));
    chk("tmo_no_vwr", 134'(out_arb_valid_wr), 134'(0));

    // Random traffic against the model
    s_prio = 0; stall = 0;
    for (int i = 0; i < 2; i++) begin
      s_rq[i] = 0; s_dw[i] = 0; s_vw[i] = 0; s_vl[i] = 0; s_dt[i] = '0;
    end
    m_port = -1; m_last = 1; m_wd = 0; m_open = 0; m_vpend = 0;
    m_cnt[0] = '0; m_cnt[1] = '0; m_err = '0;
    s_rst = 1;
    apply_s(); model_step(); tick(); compare_model();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      s_rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) s_prio = ~s_prio;
      for (int i = 0; i < 2; i++) begin
        s_rq[i] = ($urandom_range(0, 3) != 0);
        s_dw[i] = 0; s_vw[i] = 0; s_vl[i] = 0;
        k = $urandom_range(0, 9);
        t = (k < 3) ? 2'b01 : ((k < 7) ? 2'b11 : ((k < 9) ? 2'b10 : 2'b00));
        s_dt[i] = rnd_data(t);
      end
      if (stall > 0) stall--;
      else if ($urandom_range(0, 79) == 0) stall = int'(TMO) + 4;
      if (m_port >= 0 && !m_vpend && stall == 0) begin
        if ($urandom_range(0, 1) == 1) s_dw[m_port] = 1;
        if ($urandom_range(0, 5) == 0) begin
          s_vw[m_port] = 1;
          s_vl[m_port] = 1'($urandom());
        end
      end
      if ($urandom_range(0, 19) == 0) begin
        p = $urandom_range(0, 1);
        if ($urandom_range(0, 1) == 1) s_dw[p] = 1; else s_vw[p] = 1;
      end
      apply_s();
      model_step();
      tick();
      compare_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
